// File: rtl/key_action_ctrl.sv
// key_action_ctrl: turns PS/2 make/break events into single-cycle game action
// pulses. Horizontal moves use delayed auto-shift (DAS) then auto-repeat (ARR);
// soft drop repeats at a fixed period; the other actions fire once per press.
module key_action_ctrl #(
  parameter int unsigned DAS_CYCLES  = 16_000_000,
  parameter int unsigned ARR_CYCLES  = 5_000_000,
  parameter int unsigned DROP_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       make_break,
  input  logic       en,
  output logic       act_left,
  output logic       act_right,
  output logic       act_down,
  output logic       act_rot_cw,
  output logic       act_rot_ccw,
  output logic       act_hard_drop,
  output logic       act_hold,
  output logic       act_pause
);

  // Scan codes of the mapped keys (E0 prefix already removed upstream).
  localparam logic [7:0] SC_LEFT      = 8'h6B;
  localparam logic [7:0] SC_RIGHT     = 8'h74;
  localparam logic [7:0] SC_DOWN      = 8'h72;
  localparam logic [7:0] SC_ROT_CW    = 8'h75;
  localparam logic [7:0] SC_ROT_CCW   = 8'h1A;
  localparam logic [7:0] SC_HARD_DROP = 8'h29;
  localparam logic [7:0] SC_HOLD      = 8'h21;
  localparam logic [7:0] SC_PAUSE     = 8'h76;

  // Bit positions of each key in the one-hot decode and held-flag vectors.
  localparam int K_LEFT      = 0;
  localparam int K_RIGHT     = 1;
  localparam int K_DOWN      = 2;
  localparam int K_ROT_CW    = 3;
  localparam int K_ROT_CCW   = 4;
  localparam int K_HARD_DROP = 5;
  localparam int K_HOLD      = 6;
  localparam int K_PAUSE     = 7;

  localparam logic [31:0] DAS_RELOAD  = 32'(DAS_CYCLES - 1);
  localparam logic [31:0] ARR_RELOAD  = 32'(ARR_CYCLES - 1);
  localparam logic [31:0] DROP_RELOAD = 32'(DROP_CYCLES - 1);

  typedef enum logic [1:0] {
    H_IDLE,
    H_DAS,
    H_REPEAT
  } h_state_t;

  typedef enum logic {
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  // Registered copy of the input pair, used for change detection.
  logic [7:0] prev_code;
  logic       prev_mb;
  logic       evt;

  // Key decode and held-flag bookkeeping.
  logic [7:0] key_hit;
  logic [7:0] key_make_new;
  logic [7:0] key_break;
  logic [7:0] held_q;
  logic [7:0] held_d;

  // Horizontal auto-shift machine.
  h_state_t    h_state_q, h_state_d;
  dir_t        dir_q, dir_d;
  logic [31:0] h_cnt_q, h_cnt_d;
  logic        h_pulse_left;
  logic        h_pulse_right;
  logic        dir_break;
  logic        other_held;

  // Soft-drop repeat counter.
  logic [31:0] d_cnt_q, d_cnt_d;
  logic        d_pulse;

  // An event is any change of the {scan_code, make_break} pair.
  assign evt = ({scan_code, make_break} != {prev_code, prev_mb});

  // Capture the input pair every cycle for next cycle's change detection.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others; blocking here would create
    // order-dependent simulation and mismatch the synthesized flops.
    if (rst) begin
      prev_code <= 8'h00;
      prev_mb   <= 1'b0;
    end else begin
      prev_code <= scan_code;
      prev_mb   <= make_break;
    end
  end

  // One-hot decode of the incoming scan code onto the mapped keys.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    key_hit = '0;
    unique case (scan_code)
      SC_LEFT:      key_hit[K_LEFT]      = 1'b1;
      SC_RIGHT:     key_hit[K_RIGHT]     = 1'b1;
      SC_DOWN:      key_hit[K_DOWN]      = 1'b1;
      SC_ROT_CW:    key_hit[K_ROT_CW]    = 1'b1;
      SC_ROT_CCW:   key_hit[K_ROT_CCW]   = 1'b1;
      SC_HARD_DROP: key_hit[K_HARD_DROP] = 1'b1;
      SC_HOLD:      key_hit[K_HOLD]      = 1'b1;
      SC_PAUSE:     key_hit[K_PAUSE]     = 1'b1;
      default:      key_hit = '0;
    endcase
  end

  // A make only counts when the key was not already held (typematic repeats
  // from the keyboard are swallowed); a break always clears the flag.
  assign key_make_new = key_hit & ~held_q & {8{evt &  make_break}};
  assign key_break    = key_hit &           {8{evt & ~make_break}};
  assign held_d       = (held_q | key_make_new) & ~key_break;

  // Held flags for every mapped key.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q <= '0;
    end else begin
      held_q <= held_d;
    end
  end

  // Break of the currently active direction, and whether the other one is down.
  assign dir_break  = (dir_q == DIR_LEFT) ? key_break[K_LEFT] : key_break[K_RIGHT];
  assign other_held = (dir_q == DIR_LEFT) ? held_q[K_RIGHT]   : held_q[K_LEFT];

  // Horizontal FSM state, direction and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_state_q <= H_IDLE;
      dir_q     <= DIR_LEFT;
      h_cnt_q   <= '0;
    end else begin
      h_state_q <= h_state_d;
      dir_q     <= dir_d;
      h_cnt_q   <= h_cnt_d;
    end
  end

  // Horizontal next state: newest press wins, DAS delay, then ARR repeats.
  // A counter that expires in an event cycle stays at zero and fires on the
  // next event-free cycle, so the event always takes precedence.
  always_comb begin
    h_state_d     = h_state_q;
    dir_d         = dir_q;
    h_cnt_d       = h_cnt_q;
    h_pulse_left  = 1'b0;
    h_pulse_right = 1'b0;
    if (key_make_new[K_LEFT]) begin
      h_pulse_left = 1'b1;
      dir_d        = DIR_LEFT;
      h_cnt_d      = DAS_RELOAD;
      h_state_d    = H_DAS;
    end else if (key_make_new[K_RIGHT]) begin
      h_pulse_right = 1'b1;
      dir_d         = DIR_RIGHT;
      h_cnt_d       = DAS_RELOAD;
      h_state_d     = H_DAS;
    end else if ((h_state_q != H_IDLE) && dir_break) begin
      if (other_held) begin
        // Fall back to the still-held key; it must earn its DAS again.
        dir_d     = (dir_q == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
        h_cnt_d   = DAS_RELOAD;
        h_state_d = H_DAS;
      end else begin
        h_cnt_d   = '0;
        h_state_d = H_IDLE;
      end
    end else if (h_state_q != H_IDLE) begin
      if (h_cnt_q != '0) begin
        h_cnt_d = h_cnt_q - 32'd1;
      end else if (!evt) begin
        h_pulse_left  = (dir_q == DIR_LEFT);
        h_pulse_right = (dir_q == DIR_RIGHT);
        h_cnt_d       = ARR_RELOAD;
        h_state_d     = H_REPEAT;
      end
    end
  end

  // Soft-drop counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_cnt_q <= '0;
    end else begin
      d_cnt_q <= d_cnt_d;
    end
  end

  // Soft drop: immediate pulse on press, then a pulse every DROP_CYCLES.
  always_comb begin
    d_cnt_d = d_cnt_q;
    d_pulse = 1'b0;
    if (key_make_new[K_DOWN]) begin
      d_pulse = 1'b1;
      d_cnt_d = DROP_RELOAD;
    end else if (key_break[K_DOWN]) begin
      d_cnt_d = '0;
    end else if (held_q[K_DOWN]) begin
      if (d_cnt_q != '0) begin
        d_cnt_d = d_cnt_q - 32'd1;
      end else if (!evt) begin
        d_pulse = 1'b1;
        d_cnt_d = DROP_RELOAD;
      end
    end
  end

  // Registered action outputs; en gates everything except pause.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_left      <= 1'b0;
      act_right     <= 1'b0;
      act_down      <= 1'b0;
      act_rot_cw    <= 1'b0;
      act_rot_ccw   <= 1'b0;
      act_hard_drop <= 1'b0;
      act_hold      <= 1'b0;
      act_pause     <= 1'b0;
    end else begin
      act_left      <= en & h_pulse_left;
      act_right     <= en & h_pulse_right;
      act_down      <= en & d_pulse;
      act_rot_cw    <= en & key_make_new[K_ROT_CW];
      act_rot_ccw   <= en & key_make_new[K_ROT_CCW];
      act_hard_drop <= en & key_make_new[K_HARD_DROP];
      act_hold      <= en & key_make_new[K_HOLD];
      act_pause     <= key_make_new[K_PAUSE];
    end
  end

endmodule
